// File: rtl/hex_digit_scanner_if.sv
// hex_digit_scanner_if: groups the value/blanking inputs and the display
// drive outputs of the four-digit seven-segment scanner.
// Optional macro HEX_DIGIT_SCANNER_BLINK_EN adds the blink_mask signal.
interface hex_digit_scanner_if;
   logic [15:0] hex_value;
   logic        blank_lz;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  dig_n;
   logic        frame_done;
`ifdef HEX_DIGIT_SCANNER_BLINK_EN
   logic [3:0]  blink_mask;

   modport master (
      output hex_value, blank_lz, blink_mask,
      input  seg_n, dp_n, dig_n, frame_done
   );

   modport slave (
      input  hex_value, blank_lz, blink_mask,
      output seg_n, dp_n, dig_n, frame_done
   );
`else
   modport master (
      output hex_value, blank_lz,
      input  seg_n, dp_n, dig_n, frame_done
   );

   modport slave (
      input  hex_value, blank_lz,
      output seg_n, dp_n, dig_n, frame_done
   );
`endif
endinterface

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexed 4-digit common-anode seven-segment
// scanner. The displayed value is latched into a shadow register only at
// frame wrap so a mid-scan update never tears the display.
// Optional macro HEX_DIGIT_SCANNER_BLINK_EN enables per-digit blinking
// driven by a 6-bit frame counter (64-frame period, 50% duty).
module hex_digit_scanner #(
   parameter int CLK_DIV = 50000
) (
   input logic              clk,
   input logic              reset_n,
   hex_digit_scanner_if.slave bus
);

   localparam int              DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] seg_enc(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_idx;
   logic [15:0]      r_shadow;
   logic             r_frame_done;
   logic             r_out_en;
   logic [6:0]       r_seg_n;
   logic [3:0]       r_dig_n;
   logic             r_dp_n;

   logic             w_tick;
   logic             w_wrap;
   logic [3:0]       w_nib;
   logic             w_lz;
   logic             w_blink_off;
   logic [6:0]       w_seg_next;

   assign w_tick = (r_div_cnt == DIV_LAST);
   assign w_wrap = w_tick & (r_idx == 2'd3);

   // Prescaler: counts clocks within one digit slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_ONE;
      end
   end

   // Slot index, frame-boundary shadow capture and frame pulse; the display
   // stays dark until the first slot has actually started.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx        <= 2'd3;
         r_shadow     <= 16'h0000;
         r_frame_done <= 1'b0;
         r_out_en     <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_tick) begin
            r_idx    <= r_idx + 2'd1;
            r_out_en <= 1'b1;
         end else begin
            r_idx    <= r_idx;
            r_out_en <= r_out_en;
         end
         if (w_wrap) begin
            r_shadow <= bus.hex_value;
         end else begin
            r_shadow <= r_shadow;
         end
      end
   end

`ifdef HEX_DIGIT_SCANNER_BLINK_EN
   logic [5:0] r_frame_cnt;

   // Frame counter; bit 5 is the blink phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= 6'd0;
      end else if (r_frame_done) begin
         r_frame_cnt <= r_frame_cnt + 6'd1;
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end
`endif

   // Select the active nibble, its leading-zero state and the segment pattern.
   always_comb begin
      w_nib       = 4'h0;
      w_lz        = 1'b0;
      w_blink_off = 1'b0;
      case (r_idx)
         2'd0: begin
            w_nib = r_shadow[3:0];
            w_lz  = 1'b0;
         end
         2'd1: begin
            w_nib = r_shadow[7:4];
            w_lz  = (r_shadow[15:4] == 12'h000);
         end
         2'd2: begin
            w_nib = r_shadow[11:8];
            w_lz  = (r_shadow[15:8] == 8'h00);
         end
         2'd3: begin
            w_nib = r_shadow[15:12];
            w_lz  = (r_shadow[15:12] == 4'h0);
         end
         default: begin
            w_nib = 4'h0;
            w_lz  = 1'b0;
         end
      endcase
`ifdef HEX_DIGIT_SCANNER_BLINK_EN
      w_blink_off = r_frame_cnt[5] & bus.blink_mask[r_idx];
`else
      w_blink_off = 1'b0;
`endif
      if ((bus.blank_lz & w_lz) | w_blink_off) begin
         w_seg_next = 7'h7F;
      end else begin
         w_seg_next = seg_enc(w_nib);
      end
   end

   // Output stage: digit select and segments update on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dig_n <= 4'hF;
         r_seg_n <= 7'h7F;
         r_dp_n  <= 1'b1;
      end else if (r_out_en) begin
         r_dig_n <= ~(4'b0001 << r_idx);
         r_seg_n <= w_seg_next;
         r_dp_n  <= 1'b1;
      end else begin
         r_dig_n <= 4'hF;
         r_seg_n <= 7'h7F;
         r_dp_n  <= 1'b1;
      end
   end

   assign bus.seg_n      = r_seg_n;
   assign bus.dig_n      = r_dig_n;
   assign bus.dp_n       = r_dp_n;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner: randomized bench for hex_digit_scanner with a
// time-based reference model plus hand-computed literal checkpoints.
module tb_hex_digit_scanner;

   localparam int CLK_DIV = 4;
   localparam int FRAME   = 4 * CLK_DIV;
   localparam logic [6:0] ENC [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   hex_digit_scanner_if u_if ();

   hex_digit_scanner #(.CLK_DIV(CLK_DIV)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   always #5 clk = ~clk;

   // Model: edges since reset release, shadow value, expected outputs.
   int          m_n      = 0;
   logic [15:0] m_shadow = 16'h0000;
   logic [3:0]  e_dig    = 4'hF;
   logic [6:0]  e_seg    = 7'h7F;
   logic        e_fd     = 1'b0;

   function automatic bit lz_blank(input logic [15:0] v, input int i, input logic blz);
      if (i == 0 || !blz) return 1'b0;
      for (int j = i; j < 4; j++) begin
         if (v[4*j +: 4] != 4'h0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int slot_of(input int n);
      if (n < CLK_DIV) return -1;
      return ((n / CLK_DIV) - 1) % 4;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_n      = 0;
         m_shadow = 16'h0000;
         e_dig    = 4'hF;
         e_seg    = 7'h7F;
         e_fd     = 1'b0;
      end else begin
         int s;
         logic [3:0] one;
         s   = slot_of(m_n);
         one = 4'b0001;
         if (s < 0) begin
            e_dig = 4'hF;
            e_seg = 7'h7F;
         end else begin
            e_dig = ~(one << s);
            e_seg = lz_blank(m_shadow, s, u_if.blank_lz) ? 7'h7F : ENC[m_shadow[4*s +: 4]];
         end
         m_n  = m_n + 1;
         e_fd = (m_n >= CLK_DIV) && (((m_n - CLK_DIV) % FRAME) == 0);
         if (e_fd) m_shadow = u_if.hex_value;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      n_total++;
      if (u_if.dig_n !== e_dig || u_if.seg_n !== e_seg || u_if.frame_done !== e_fd ||
          u_if.dp_n !== 1'b1) begin
         $display("FAIL model t=%0t dig=%h/%h seg=%h/%h fd=%b/%b dp=%b/1 (actual/required)",
                  $time, u_if.dig_n, e_dig, u_if.seg_n, e_seg, u_if.frame_done, e_fd, u_if.dp_n);
      end else begin
         n_pass++;
      end
   end

   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk_lit(input string name, input logic [3:0] dig, input logic [6:0] seg);
      n_total++;
      if (u_if.dig_n !== dig || u_if.seg_n !== seg) begin
         $display("FAIL %s dig=%h seg=%h required dig=%h seg=%h", name, u_if.dig_n, u_if.seg_n, dig, seg);
      end else begin
         n_pass++;
      end
   endtask

   task automatic chk_fd(input string name, input logic fd);
      n_total++;
      if (u_if.frame_done !== fd) begin
         $display("FAIL %s frame_done=%b required %b", name, u_if.frame_done, fd);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      bit found;
      u_if.hex_value = 16'h1234;
      u_if.blank_lz  = 1'b0;
`ifdef HEX_DIGIT_SCANNER_BLINK_EN
      u_if.blink_mask = 4'h0;
`endif
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk_lit("reset_dark", 4'hF, 7'h7F);
      chk_fd("reset_fd", 1'b0);
      step(2);
      reset_n = 1'b1;

      // First frame, value 1234.
      step(3);
      chk_fd("pre_tick_fd", 1'b0);
      step(1);
      chk_fd("first_tick_fd", 1'b1);
      chk_lit("still_dark", 4'hF, 7'h7F);
      step(1);
      chk_lit("d0_4", 4'hE, 7'h19);
      step(4);
      chk_lit("d1_3", 4'hD, 7'h30);
      step(4);
      chk_lit("d2_2", 4'hB, 7'h24);
      step(4);
      chk_lit("d3_1", 4'h7, 7'h79);

      // Tear-free update: change during idx=1 of the next frame.
      step(8);
      u_if.hex_value = 16'hABCD;
      step(4);
      chk_lit("tear_d2", 4'hB, 7'h24);
      step(4);
      chk_lit("tear_d3", 4'h7, 7'h79);
      step(4);
      chk_lit("new_d0", 4'hE, 7'h21);
      step(4);
      chk_lit("new_d1", 4'hD, 7'h46);
      step(4);
      chk_lit("new_d2", 4'hB, 7'h03);
      step(4);
      chk_lit("new_d3", 4'h7, 7'h08);

      // Leading-zero blanking.
      u_if.hex_value = 16'h0050;
      u_if.blank_lz  = 1'b1;
      step(4);
      chk_lit("lz_d0", 4'hE, 7'h40);
      step(4);
      chk_lit("lz_d1", 4'hD, 7'h12);
      step(4);
      chk_lit("lz_d2", 4'hB, 7'h7F);
      step(4);
      chk_lit("lz_d3", 4'h7, 7'h7F);
      u_if.hex_value = 16'h0000;
      step(4);
      chk_lit("zero_d0", 4'hE, 7'h40);
      step(4);
      chk_lit("zero_d1", 4'hD, 7'h7F);
      step(8);
      chk_lit("zero_d3", 4'h7, 7'h7F);

      // Full encoding sweep, every digit equal.
      u_if.blank_lz = 1'b0;
      for (int v = 0; v < 16; v++) begin
         u_if.hex_value = 16'(v) * 16'h1111;
         step(FRAME + 1);
      end

      // Randomized values and blanking toggles.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) u_if.hex_value = 16'($urandom);
         if ($urandom_range(0, 15) == 0) u_if.blank_lz = ~u_if.blank_lz;
         if ($urandom_range(0, 5) == 0) u_if.hex_value[15:8] = 8'h00;
         step(1);
      end

      // Async reset while slot 2 is active.
      found = 1'b0;
      for (int c = 0; c < FRAME + 2 && !found; c++) begin
         if (slot_of(m_n) == 2) found = 1'b1;
         else step(1);
      end
      n_total++;
      if (!found) $display("FAIL wait_slot2 found=0 required 1");
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      chk_lit("async_dark", 4'hF, 7'h7F);
      chk_fd("async_fd", 1'b0);
      @(negedge clk);
      step(2);
      reset_n = 1'b1;
      step(CLK_DIV - 1);
      chk_fd("rst_pre_tick", 1'b0);
      step(1);
      chk_fd("rst_first_tick", 1'b1);
      step(2 * FRAME);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
